// File: rtl/conv_ram_reader_if.sv
// ============================================================================
// Module      : conv_ram_reader_if
// Description : Control, RAM read-port and MAC-tag bundle for conv_ram_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_ram_reader_if #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int K       = 3,
    parameter int NUM_KER = 6
);
    localparam int c_OH   = IMG_H - K + 1;
    localparam int c_OW   = IMG_W - K + 1;
    localparam int c_DA_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1;
    localparam int c_WA_W = (K * K * NUM_KER > 1) ? $clog2(K * K * NUM_KER) : 1;
    localparam int c_KI_W = (NUM_KER > 1) ? $clog2(NUM_KER) : 1;
    localparam int c_OR_W = (c_OH > 1) ? $clog2(c_OH) : 1;
    localparam int c_OC_W = (c_OW > 1) ? $clog2(c_OW) : 1;

    logic              start;
    logic              load_done;
    logic              acc_ready;
    logic [c_DA_W-1:0] data_ram_raddr;
    logic [c_WA_W-1:0] weight_ram_raddr;
    logic              data_ram_ren;
    logic              weight_ram_ren;
    logic              rd_valid;
    logic              win_first;
    logic              win_last;
    logic [c_KI_W-1:0] ker_idx;
    logic [c_OR_W-1:0] out_row;
    logic [c_OC_W-1:0] out_col;
    logic              busy;
    logic              done;

    modport master (
        input  start, load_done, acc_ready,
        output data_ram_raddr, weight_ram_raddr, data_ram_ren, weight_ram_ren,
        output rd_valid, win_first, win_last, ker_idx, out_row, out_col,
        output busy, done
    );

    modport slave (
        output start, load_done, acc_ready,
        input  data_ram_raddr, weight_ram_raddr, data_ram_ren, weight_ram_ren,
        input  rd_valid, win_first, win_last, ker_idx, out_row, out_col,
        input  busy, done
    );
endinterface

`default_nettype wire

// File: rtl/conv_ram_reader.sv
// ============================================================================
// Module      : conv_ram_reader
// Description : Walks every tap of every output pixel of every kernel of a
//               stride-1 KxK convolution, one RAM read pair per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_ram_reader #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int K       = 3,
    parameter int NUM_KER = 6
) (
    input  logic               clk,
    input  logic               rst,
    conv_ram_reader_if.master  bus
);
    localparam int c_OH   = IMG_H - K + 1;
    localparam int c_OW   = IMG_W - K + 1;
    localparam int c_DA_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1;
    localparam int c_WA_W = (K * K * NUM_KER > 1) ? $clog2(K * K * NUM_KER) : 1;
    localparam int c_KI_W = (NUM_KER > 1) ? $clog2(NUM_KER) : 1;
    localparam int c_OR_W = (c_OH > 1) ? $clog2(c_OH) : 1;
    localparam int c_OC_W = (c_OW > 1) ? $clog2(c_OW) : 1;
    localparam int c_KT_W = (K > 1) ? $clog2(K) : 1;

    localparam logic [c_KT_W-1:0] c_TAP_MAX = c_KT_W'(K - 1);
    localparam logic [c_OC_W-1:0] c_COL_MAX = c_OC_W'(c_OW - 1);
    localparam logic [c_OR_W-1:0] c_ROW_MAX = c_OR_W'(c_OH - 1);
    localparam logic [c_KI_W-1:0] c_KER_MAX = c_KI_W'(NUM_KER - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [c_KI_W-1:0] k_q, k_d;
    logic [c_OR_W-1:0] r_q, r_d;
    logic [c_OC_W-1:0] c_q, c_d;
    logic [c_KT_W-1:0] ky_q, ky_d;
    logic [c_KT_W-1:0] kx_q, kx_d;

    logic              rd_valid_q;
    logic              first_q;
    logic              last_q;
    logic [c_KI_W-1:0] ker_q;
    logic [c_OR_W-1:0] row_q;
    logic [c_OC_W-1:0] col_q;

    logic w_issue;
    logic w_tap_first;
    logic w_tap_last;
    logic w_final;

    assign w_issue     = (state_q == c_ST_RUN) && bus.acc_ready;
    assign w_tap_first = (ky_q == '0) && (kx_q == '0);
    assign w_tap_last  = (ky_q == c_TAP_MAX) && (kx_q == c_TAP_MAX);
    assign w_final     = w_tap_last && (c_q == c_COL_MAX) && (r_q == c_ROW_MAX)
                         && (k_q == c_KER_MAX);

    // Nested odometer: kx is the fastest digit, kernel index the slowest.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.start && bus.load_done) begin
                    state_d = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_issue) begin
                    if (kx_q == c_TAP_MAX) begin
                        kx_d = '0;
                        if (ky_q == c_TAP_MAX) begin
                            ky_d = '0;
                            if (c_q == c_COL_MAX) begin
                                c_d = '0;
                                if (r_q == c_ROW_MAX) begin
                                    r_d = '0;
                                    k_d = (k_q == c_KER_MAX) ? '0 : k_q + 1'b1;
                                end else begin
                                    r_d = r_q + 1'b1;
                                end
                            end else begin
                                c_d = c_q + 1'b1;
                            end
                        end else begin
                            ky_d = ky_q + 1'b1;
                        end
                    end else begin
                        kx_d = kx_q + 1'b1;
                    end
                    if (w_final) begin
                        state_d = c_ST_DRAIN;
                    end
                end
            end
            c_ST_DRAIN: begin
                state_d = c_ST_DONE;
            end
            c_ST_DONE: begin
                state_d = c_ST_IDLE;
                k_d     = '0;
                r_d     = '0;
                c_d     = '0;
                ky_d    = '0;
                kx_d    = '0;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            r_q     <= r_d;
            c_q     <= c_d;
            ky_q    <= ky_d;
            kx_q    <= kx_d;
        end
    end

    // Tags trail the issue by one cycle to line up with the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            ker_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            rd_valid_q <= w_issue;
            first_q    <= w_issue && w_tap_first;
            last_q     <= w_issue && w_tap_last;
            if (w_issue) begin
                ker_q <= k_q;
                row_q <= r_q;
                col_q <= c_q;
            end
        end
    end

    assign bus.data_ram_raddr   = c_DA_W'((c_DA_W'(r_q) + c_DA_W'(ky_q)) * c_DA_W'(IMG_W)
                                          + c_DA_W'(c_q) + c_DA_W'(kx_q));
    assign bus.weight_ram_raddr = c_WA_W'(c_WA_W'(k_q) * c_WA_W'(K * K)
                                          + c_WA_W'(ky_q) * c_WA_W'(K) + c_WA_W'(kx_q));
    assign bus.data_ram_ren     = w_issue;
    assign bus.weight_ram_ren   = w_issue;
    assign bus.rd_valid         = rd_valid_q;
    assign bus.win_first        = first_q;
    assign bus.win_last         = last_q;
    assign bus.ker_idx          = ker_q;
    assign bus.out_row          = row_q;
    assign bus.out_col          = col_q;
    assign bus.busy             = (state_q == c_ST_RUN) || (state_q == c_ST_DRAIN);
    assign bus.done             = (state_q == c_ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_conv_ram_reader.sv
// ============================================================================
// Module      : tb_conv_ram_reader
// Description : Randomized self-checking bench for conv_ram_reader against a
//               loop-nest reference of the expected read sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_ram_reader;
    localparam int IMG_W   = 8;
    localparam int IMG_H   = 8;
    localparam int K       = 3;
    localparam int NUM_KER = 6;
    localparam int OH      = IMG_H - K + 1;
    localparam int OW      = IMG_W - K + 1;
    localparam int TOTAL   = NUM_KER * OH * OW * K * K;
    localparam int WINDOWS = NUM_KER * OH * OW;

    logic clk = 1'b0;
    logic rst;

    conv_ram_reader_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .NUM_KER(NUM_KER)) bus ();

    conv_ram_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .NUM_KER(NUM_KER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference sequence straight from the loop nest and address formulas.
    int exp_d [TOTAL];
    int exp_w [TOTAL];
    int exp_k [TOTAL];
    int exp_r [TOTAL];
    int exp_c [TOTAL];
    int exp_f [TOTAL];
    int exp_l [TOTAL];

    int got_d  [TOTAL];
    int got_w  [TOTAL];
    int got_bk [TOTAL];
    int got_br [TOTAL];
    int got_bc [TOTAL];
    int got_bf [TOTAL];
    int got_bl [TOTAL];

    int cyc       = 0;
    int iss_idx   = 0;
    int beat_idx  = 0;
    int last_cnt  = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int start_cyc = 0;
    bit prev_ren  = 1'b0;
    bit mon_on    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_on) begin
            check_eq("ren_pair", bus.weight_ram_ren, bus.data_ram_ren);
            check_eq("rdv_follows_ren", bus.rd_valid, prev_ren);
            if (bus.data_ram_ren) begin
                if (iss_idx < TOTAL) begin
                    check_eq("issue_daddr", bus.data_ram_raddr, exp_d[iss_idx]);
                    check_eq("issue_waddr", bus.weight_ram_raddr, exp_w[iss_idx]);
                    got_d[iss_idx] = int'(bus.data_ram_raddr);
                    got_w[iss_idx] = int'(bus.weight_ram_raddr);
                end else begin
                    check_eq("extra_issue", iss_idx, TOTAL - 1);
                end
                iss_idx++;
            end
            if (bus.rd_valid) begin
                if (beat_idx < TOTAL) begin
                    check_eq("beat_ker", bus.ker_idx, exp_k[beat_idx]);
                    check_eq("beat_row", bus.out_row, exp_r[beat_idx]);
                    check_eq("beat_col", bus.out_col, exp_c[beat_idx]);
                    check_eq("beat_first", bus.win_first, exp_f[beat_idx]);
                    check_eq("beat_last", bus.win_last, exp_l[beat_idx]);
                    got_bk[beat_idx] = int'(bus.ker_idx);
                    got_br[beat_idx] = int'(bus.out_row);
                    got_bc[beat_idx] = int'(bus.out_col);
                    got_bf[beat_idx] = int'(bus.win_first);
                    got_bl[beat_idx] = int'(bus.win_last);
                end else begin
                    check_eq("extra_beat", beat_idx, TOTAL - 1);
                end
                if (bus.win_last) last_cnt++;
                beat_idx++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("busy_at_done", bus.busy, 0);
            end
            prev_ren = bus.data_ram_ren && !rst;
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_dren"}, bus.data_ram_ren, 0);
        check_eq({tag, "_wren"}, bus.weight_ram_ren, 0);
        check_eq({tag, "_daddr"}, bus.data_ram_raddr, 0);
        check_eq({tag, "_waddr"}, bus.weight_ram_raddr, 0);
        check_eq({tag, "_rdv"}, bus.rd_valid, 0);
        check_eq({tag, "_first"}, bus.win_first, 0);
        check_eq({tag, "_last"}, bus.win_last, 0);
        check_eq({tag, "_ker"}, bus.ker_idx, 0);
        check_eq({tag, "_row"}, bus.out_row, 0);
        check_eq({tag, "_col"}, bus.out_col, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_done"}, bus.done, 0);
    endtask

    // mode 0: ready high plus stray start; 1: random ready; 2: 3-cycle stall;
    // 3: reset once 500 beats have been seen.
    task automatic run_pass(input int mode, input int exp_lat);
        int  t;
        int  rel;
        bit  aborted;
        iss_idx       = 0;
        beat_idx      = 0;
        last_cnt      = 0;
        done_cnt      = 0;
        done_cyc      = -1;
        aborted       = 1'b0;
        t             = 0;
        bus.load_done = 1'b1;
        bus.acc_ready = 1'b1;
        bus.start     = 1'b1;
        start_cyc     = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (done_cnt == 0 && t < 8000 && !aborted) begin
            rel = cyc - start_cyc;
            case (mode)
                0: bus.start = (rel == 700);
                1: bus.acc_ready = ($urandom_range(0, 3) != 0);
                2: bus.acc_ready = !(rel >= 100 && rel < 103);
                default: begin
                    if (beat_idx == 500) begin
                        rst     = 1'b1;
                        aborted = 1'b1;
                    end
                end
            endcase
            @(posedge clk); #1;
            t++;
        end
        bus.start     = 1'b0;
        bus.acc_ready = 1'b1;
        if (aborted) begin
            rst = 1'b0;
            @(negedge clk);
            check_all_zero("abort");
            repeat (5) @(negedge clk);
            check_eq("abort_no_done", done_cnt, 0);
            check_eq("abort_idle", bus.busy, 0);
        end else begin
            check_eq("pass_done_seen", (done_cnt > 0) ? 1 : 0, 1);
            repeat (3) @(negedge clk);
            check_eq("pass_done_once", done_cnt, 1);
            check_eq("pass_issues", iss_idx, TOTAL);
            check_eq("pass_beats", beat_idx, TOTAL);
            check_eq("pass_win_last", last_cnt, WINDOWS);
            check_eq("pass_idle_busy", bus.busy, 0);
            if (exp_lat > 0) begin
                check_eq("pass_latency", done_cyc - start_cyc, exp_lat);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int idx;
        int sd [9];
        sd = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        idx = 0;
        for (int k = 0; k < NUM_KER; k++)
            for (int r = 0; r < OH; r++)
                for (int c = 0; c < OW; c++)
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++) begin
                            exp_d[idx] = (r + ky) * IMG_W + (c + kx);
                            exp_w[idx] = k * K * K + ky * K + kx;
                            exp_k[idx] = k;
                            exp_r[idx] = r;
                            exp_c[idx] = c;
                            exp_f[idx] = (ky == 0 && kx == 0) ? 1 : 0;
                            exp_l[idx] = (ky == K - 1 && kx == K - 1) ? 1 : 0;
                            idx++;
                        end

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.load_done = 1'b0;
        bus.acc_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_on = 1'b1;

        // start without load_done is dropped, and not remembered later
        bus.acc_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.load_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("noload_busy", bus.busy, 0);
            check_eq("noload_ren", bus.data_ram_ren, 0);
        end
        @(posedge clk); #1;

        run_pass(0, 1946);
        for (int i = 0; i < 9; i++) begin
            check_eq("first9_daddr", got_d[i], sd[i]);
            check_eq("first9_waddr", got_w[i], i);
        end
        check_eq("beat0_first", got_bf[0], 1);
        check_eq("beat8_last", got_bl[8], 1);
        check_eq("beat9_daddr", got_d[9], 1);
        check_eq("beat9_waddr", got_w[9], 0);
        check_eq("beat9_col", got_bc[9], 1);
        check_eq("beat324_ker", got_bk[324], 1);
        check_eq("beat324_waddr", got_w[324], 9);
        check_eq("beat324_daddr", got_d[324], 0);
        check_eq("beat324_first", got_bf[324], 1);
        check_eq("lastbeat_daddr", got_d[TOTAL-1], 63);
        check_eq("lastbeat_waddr", got_w[TOTAL-1], 53);
        check_eq("lastbeat_ker", got_bk[TOTAL-1], 5);
        check_eq("lastbeat_row", got_br[TOTAL-1], 5);
        check_eq("lastbeat_col", got_bc[TOTAL-1], 5);

        run_pass(1, 0);
        run_pass(2, 1949);
        run_pass(3, 0);
        run_pass(0, 1946);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
